// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the Down FIFO controller.
// Holds the depth function and default flag thresholds.
package fifo_pkg;

  localparam int unsigned AlmostEmptyDefault = 2;
  localparam int unsigned AlmostFullMargin   = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping FIFO pointer with increment enable and synchronous active-low clear.
// Wraps from 2**WIDTH-1 back to 0.
module fifo_ptr_cnt #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/down_fifo_ctrl.sv
// Down FIFO controller: pointers, occupancy and flags for an external distributed
// simple-dual-port RAM with combinational read; standard (non-FWFT) pop interface.
module down_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned ALMOST_FULL_NUM  = fifo_depth(ADDR_WIDTH) - AlmostFullMargin,
  parameter int unsigned ALMOST_EMPTY_NUM = AlmostEmptyDefault
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0] AfNum    = (ADDR_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AeNum    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_bad_addr_width
    $error("down_fifo_ctrl: ADDR_WIDTH must be within 4..10");
  end
  if (ALMOST_FULL_NUM > Depth) begin : g_bad_almost_full
    $error("down_fifo_ctrl: ALMOST_FULL_NUM must not exceed the FIFO depth");
  end

  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, almost_full_q, empty_q, almost_empty_q;
  logic                  overflow_q, underflow_q, rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Gating with rst_n keeps the RAM from being written while reset is held.
  assign wr_acc = rst_n & wr_en & ~full_q;
  assign rd_acc = rst_n & rd_en & ~empty_q;

  fifo_ptr_cnt #(
    .WIDTH(ADDR_WIDTH + 1)
  ) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wr_acc),
    .ptr  (wr_ptr)
  );

  fifo_ptr_cnt #(
    .WIDTH(ADDR_WIDTH + 1)
  ) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rd_acc),
    .ptr  (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      count_q        <= count_d;
      full_q         <= (count_d == DepthCnt);
      almost_full_q  <= (count_d >= AfNum);
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= AeNum);
      overflow_q     <= wr_en & full_q;
      underflow_q    <= rd_en & empty_q;
      rd_valid_q     <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= ram_rd_data;
      end
    end
  end

  // Pointer distance must always track the occupancy counter.
  logic [ADDR_WIDTH:0] ptr_diff;
  assign ptr_diff = wr_ptr - rd_ptr;

  assert property (@(posedge clk) disable iff (!rst_n) ptr_diff == count_q)
    else $error("down_fifo_ctrl: pointer distance disagrees with data_count");

  assign ram_wr_en    = wr_acc;
  assign ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data  = wr_data;
  assign ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign data_count   = count_q;

endmodule

// File: tb/tb_down_fifo_ctrl.sv
// Self-checking bench for down_fifo_ctrl: queue-based reference model, a behavioural
// RAM, directed boundary sequences and a randomized phase with occasional resets.
module tb_down_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          full, almost_full, overflow;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, almost_empty, underflow;
  logic [AW:0]   data_count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  down_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .almost_empty(almost_empty),
    .underflow   (underflow),
    .data_count  (data_count),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Distributed RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  // Reference model state.
  logic [DW-1:0] q[$];
  int            m_wp, m_rp;
  logic [DW-1:0] m_rd_data;
  bit            m_rv, m_ov, m_uf;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("data_count", data_count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", almost_full, q.size() >= DEPTH - 2);
    chk("empty", empty, q.size() == 0);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_uf);
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd_data);
  endtask

  // One clock: drive, check the combinational RAM drive, clock, update model, check.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit rs);
    bit is_full, is_empty, wa, ra;
    wr_en = w; wr_data = d; rd_en = r; rst_n = rs;
    #2;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    wa = rs && w && !is_full;
    ra = rs && r && !is_empty;
    chk("ram_wr_en", ram_wr_en, wa);
    chk("ram_rd_addr", ram_rd_addr, m_rp % DEPTH);
    if (wa) begin
      chk("ram_wr_addr", ram_wr_addr, m_wp % DEPTH);
      chk("ram_wr_data", ram_wr_data, d);
    end
    @(posedge clk);
    if (!rs) begin
      q.delete();
      m_wp = 0; m_rp = 0;
      m_rv = 0; m_ov = 0; m_uf = 0;
      m_rd_data = '0;
    end else begin
      m_ov = w && is_full;
      m_uf = r && is_empty;
      m_rv = ra;
      if (ra) begin
        m_rd_data = q.pop_front();
        m_rp++;
      end
      if (wa) begin
        q.push_back(d);
        m_wp++;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    wr_en = 0; rd_en = 0; wr_data = '0; rst_n = 0;
    m_wp = 0; m_rp = 0; m_rv = 0; m_ov = 0; m_uf = 0; m_rd_data = '0;

    // Reset held with a push request.
    repeat (3) cycle(1, 16'hdead, 0, 0);
    chk("rst_empty_lit", empty, 1);
    chk("rst_count_lit", data_count, 0);

    // Fill.
    for (int i = 1; i <= 16; i++) begin
      cycle(1, DW'(i), 0, 1);
      if (i == 13) chk("af_before_14_lit", almost_full, 0);
      if (i == 14) chk("af_after_14_lit", almost_full, 1);
    end
    chk("fill_full_lit", full, 1);
    chk("fill_count_lit", data_count, 16);
    cycle(1, 16'h0011, 0, 1);
    chk("ovf_pulse_lit", overflow, 1);
    chk("ovf_count_lit", data_count, 16);
    cycle(0, 0, 0, 1);
    chk("ovf_drop_lit", overflow, 0);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 1, 1);
      if (i == 1) chk("drain_first_lit", rd_data, 16'h0001);
      if (i == 16) chk("drain_last_lit", rd_data, 16'h0010);
    end
    chk("drain_empty_lit", empty, 1);
    cycle(0, 0, 1, 1);
    chk("udf_pulse_lit", underflow, 1);
    chk("udf_no_valid_lit", rd_valid, 0);

    // Wrap: push/pop pairs then a burst, then drain.
    for (int i = 0; i < 10; i++) cycle(1, DW'(16'h0100 + i), 1, 1);
    for (int i = 0; i < 12; i++) cycle(1, DW'(16'h0200 + i), 0, 1);
    while (q.size() > 0) cycle(0, 0, 1, 1);
    chk("wrap_last_lit", rd_data, 16'h020b);

    // Simultaneous at full.
    for (int i = 0; i < 16; i++) cycle(1, DW'(16'h0300 + i), 0, 1);
    cycle(1, 16'hbeef, 1, 1);
    chk("simfull_data_lit", rd_data, 16'h0300);
    chk("simfull_ovf_lit", overflow, 1);
    chk("simfull_count_lit", data_count, 15);

    // Simultaneous at empty.
    while (q.size() > 0) cycle(0, 0, 1, 1);
    cycle(1, 16'h0400, 1, 1);
    chk("simempty_count_lit", data_count, 1);
    chk("simempty_udf_lit", underflow, 1);
    chk("simempty_valid_lit", rd_valid, 0);

    // Reset mid-stream with a pop pending.
    for (int i = 1; i < 5; i++) cycle(1, DW'(16'h0400 + i), 0, 1);
    cycle(0, 0, 1, 0);
    chk("midrst_valid_lit", rd_valid, 0);
    chk("midrst_empty_lit", empty, 1);
    chk("midrst_count_lit", data_count, 0);

    // Randomized traffic with varying push/pop rates.
    for (int seg = 0; seg < 40; seg++) begin
      int wp = $urandom_range(10, 90);
      int rp = $urandom_range(10, 90);
      for (int c = 0; c < 80; c++) begin
        cycle($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 299) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
